fp8_dot_acc: RTL

Streaming accumulator directly downstream of the FP8 multiplier (1 sign, 3 exponent, 4 mantissa bits, bias 3). Consumes a stream of FP8 products, sums one vector delimited by s_last, and emits one FP8 dot-product result per vector. Summation runs in exact signed fixed point, with a single FP8 conversion at the end. Valid/ready handshakes are used on both sides.

---
 rtl/fp8_dot_acc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fp8_dot_acc.sv
// fp8_dot_acc: sums a stream of FP8 (1s/3e/4m, bias 3) products per vector
// in signed fixed point (6 frac bits) and emits one FP8 result per s_last.
// Ports: clk, rst_n (async, active-low)
//   s_valid/s_ready/s_data[7:0]/s_last : product beat stream in
//   m_valid/m_ready/m_data[7:0]/m_cnt  : result out, m_cnt = beats (sat)
//   m_sat (only with FP8_ACC_SAT_FLAG_EN): acc saturated or output clamped
module fp8_dot_acc #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic [CNT_W-1:0] m_cnt
`ifdef FP8_ACC_SAT_FLAG_EN
  ,
  output logic             m_sat
`endif
);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Symmetric clamp limits, held one bit wider for the overflow compare.
  localparam logic signed [ACC_W:0] WMAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] WMIN =
    {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] SMAX = WMAX[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] SMIN = WMIN[ACC_W-1:0];
  localparam logic [ACC_W-1:0] CLAMP_MAG = ACC_W'(1984);

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    first_q;

  logic                    accept;
  logic signed [ACC_W-1:0] fx;
  logic signed [ACC_W:0]   wide;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        sum_abs;
  logic                    sat_now;
  logic [CNT_W-1:0]        cnt_n;
  logic [7:0]              fp8_n;

  // FP8 -> signed fixed point with 6 fraction bits.
  function automatic logic signed [ACC_W-1:0] to_fix(
    input logic [7:0] d
  );
    logic [11:0]             mag;
    logic signed [ACC_W-1:0] ext;
    if (d[6:4] == 3'd0)
      mag = {8'd0, d[3:0]};
    else
      mag = {7'd0, 1'b1, d[3:0]} << (d[6:4] - 3'd1);
    ext = {{(ACC_W-12){1'b0}}, mag};
    return d[7] ? -ext : ext;
  endfunction

  // Magnitude -> FP8, truncating; leading one picks the exponent.
  function automatic logic [7:0] to_fp8(
    input logic             s,
    input logic [ACC_W-1:0] m
  );
    logic [2:0] e;
    logic [3:0] mt;
    e  = 3'd0;
    mt = m[3:0];
    priority case (1'b1)
      m[10]: begin e = 3'd7; mt = m[9:6]; end
      m[9]:  begin e = 3'd6; mt = m[8:5]; end
      m[8]:  begin e = 3'd5; mt = m[7:4]; end
      m[7]:  begin e = 3'd4; mt = m[6:3]; end
      m[6]:  begin e = 3'd3; mt = m[5:2]; end
      m[5]:  begin e = 3'd2; mt = m[4:1]; end
      m[4]:  begin e = 3'd1; mt = m[3:0]; end
      default: begin e = 3'd0; mt = m[3:0]; end
    endcase
    if (m == '0)
      return 8'h00;
    else if (m >= CLAMP_MAG)
      return {s, 7'h7F};
    else
      return {s, e, mt};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC: if (s_valid && s_last) state_d = OUT;
      OUT: if (m_ready)           state_d = ACC;
      default:                    state_d = ACC;
    endcase
  end

  always_comb begin
    s_ready = (state_q == ACC);
    m_valid = (state_q == OUT);
  end

  assign accept = s_valid && s_ready;

  always_comb begin
    fx      = to_fix(s_data);
    wide    = {acc_q[ACC_W-1], acc_q} + {fx[ACC_W-1], fx};
    sum     = wide[ACC_W-1:0];
    sat_now = 1'b0;
    if (first_q) begin
      sum = fx;
    end else if (wide > WMAX) begin
      sum     = SMAX;
      sat_now = 1'b1;
    end else if (wide < WMIN) begin
      sum     = SMIN;
      sat_now = 1'b1;
    end
    sum_abs = sum[ACC_W-1] ? $unsigned(-sum) : $unsigned(sum);
    fp8_n   = to_fp8(sum[ACC_W-1], sum_abs);
    if (first_q)
      cnt_n = CNT_W'(1);
    else if (&cnt_q)
      cnt_n = cnt_q;
    else
      cnt_n = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      m_data  <= 8'h00;
      m_cnt   <= '0;
    end else if (accept) begin
      acc_q   <= sum;
      cnt_q   <= cnt_n;
      first_q <= s_last;
      if (s_last) begin
        m_data <= fp8_n;
        m_cnt  <= cnt_n;
      end
    end
  end

`ifdef FP8_ACC_SAT_FLAG_EN
  logic sat_q;
  logic sat_vec;
  logic clamp;

  assign sat_vec = (first_q ? 1'b0 : sat_q) | sat_now;
  assign clamp   = (sum_abs >= CLAMP_MAG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      m_sat <= 1'b0;
    end else if (accept) begin
      sat_q <= sat_vec;
      if (s_last) m_sat <= sat_vec | clamp;
    end
  end
`endif

endmodule
